gpio_pinmux: RTL

GPIO_PINMUX -- requirements
Module: gpio_pinmux

---
 rtl/gpio_pinmux.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/gpio_pinmux.sv
// rtl/gpio_pinmux.sv - GPIO pad multiplexer between croc and user domains with dead-time handover (optional macro: GPIO_PINMUX_LOCK_EN)
module gpio_pinmux #(
    parameter int unsigned              GpioCount  = 16,
    parameter int unsigned              DeadCycles = 2,
    parameter logic [2*GpioCount-1:0]   ResetMode  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [3:0]           addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    input  logic [GpioCount-1:0] croc_gpio_i,
    input  logic [GpioCount-1:0] croc_oe_i,
    input  logic [GpioCount-1:0] user_gpio_i,
    input  logic [GpioCount-1:0] user_oe_i,
    output logic [GpioCount-1:0] gpio_o,
    output logic [GpioCount-1:0] gpio_out_en_o,
    input  logic [GpioCount-1:0] gpio_i,
    output logic [GpioCount-1:0] gpio_in_sync_o
);

    localparam int unsigned ModeW = 2 * GpioCount;

    typedef enum logic {IDLE, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ModeW-1:0]     mode_q, mode_d;
    logic [ModeW-1:0]     pend_q, pend_d;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic [GpioCount-1:0] gpio_q, gpio_d;
    logic [GpioCount-1:0] oe_q, oe_d;
    logic [GpioCount-1:0] sync1_q, sync2_q;
    logic [GpioCount-1:0] use_user, blank;

    logic [1:0]           word;
    logic                 accept;
    logic                 mode_wr;
    logic                 locked;
    logic [63:0]          mode_ext;
    logic [63:0]          wr_full;
    logic [ModeW-1:0]     wr_mode;
    logic [31:0]          rd_word;
    logic                 unused_bits;

    assign word     = addr_i[3:2];
    assign gnt_o    = req_i & (state_q == IDLE);
    assign accept   = gnt_o;
    // Zero extension makes fields of non-existent pins read 0 and drop writes.
    assign mode_ext = 64'(mode_q);
    assign wr_mode  = wr_full[ModeW-1:0];
    assign mode_wr  = accept & we_i & ~word[1] & ~locked;
    assign unused_bits = ^{addr_i[1:0], wr_full};

`ifdef GPIO_PINMUX_LOCK_EN
    logic lock_q;

    // Sticky lock: once a 1 is written it holds until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (accept && we_i && word == 2'd3 && wdata_i[0]) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // Merge the written word into the full 32-pin mode image.
    always_comb begin
        wr_full = mode_ext;
        if (word == 2'd0) begin
            wr_full[31:0] = wdata_i;
        end else if (word == 2'd1) begin
            wr_full[63:32] = wdata_i;
        end
    end

    // Register read mux.
    always_comb begin
        rd_word = '0;
        case (word)
            2'd0:    rd_word = mode_ext[31:0];
            2'd1:    rd_word = mode_ext[63:32];
            2'd2:    rd_word = {31'b0, state_q == DRAIN};
            default: rd_word = {31'b0, locked};
        endcase
    end

    // Handover FSM: a mode change blanks the changed pins for DeadCycles before applying.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (mode_wr) begin
                    pend_d = wr_mode;
                    if (wr_mode != mode_q) begin
                        cnt_d   = 4'(DeadCycles);
                        state_d = DRAIN;
                    end else begin
                        mode_d = wr_mode;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    mode_d  = pend_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-pin owner selection; changed pins are blanked while draining.
    always_comb begin
        use_user = '0;
        blank    = '0;
        gpio_d   = '0;
        oe_d     = '0;
        for (int n = 0; n < GpioCount; n++) begin
            use_user[n] = (mode_q[2*n +: 2] == 2'd1) ||
                          ((mode_q[2*n +: 2] == 2'd2) && user_oe_i[n]);
            blank[n]    = (mode_q[2*n +: 2] == 2'd3) ||
                          ((state_q == DRAIN) && (pend_q[2*n +: 2] != mode_q[2*n +: 2]));
            if (!blank[n]) begin
                gpio_d[n] = use_user[n] ? user_gpio_i[n] : croc_gpio_i[n];
                oe_d[n]   = use_user[n] ? user_oe_i[n]   : croc_oe_i[n];
            end
        end
    end

    // State, mode, response and pad registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mode_q   <= ResetMode;
            pend_q   <= ResetMode;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            gpio_q   <= '0;
            oe_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            rvalid_q <= accept;
            rdata_q  <= (accept && !we_i) ? rd_word : '0;
            gpio_q   <= gpio_d;
            oe_q     <= oe_d;
        end
    end

    // Two-flop synchroniser for the raw pad inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign gpio_o         = gpio_q;
    assign gpio_out_en_o  = oe_q;
    assign gpio_in_sync_o = sync2_q;

endmodule
